ram_nr1w_wr_arb: RTL and testbench

Write-port controller for the N-read/1-write RAM core. Shares the single RAM write port between REQ_NB requesters using valid/ready and round-robin arbitration. Also owns a sequenced init engine that sweeps every address with INIT_VAL, after reset or on request. Drives the RAM write port through a registered stage; read ports are untouched.

---
 rtl/ram_nr1w_wr_arb_pkg.sv | 10 +
 rtl/ram_nr1w_wr_arb_rr_arbiter.sv | 51 +++++
 rtl/ram_nr1w_wr_arb.sv | 103 ++++++++++
 tb/tb_ram_nr1w_wr_arb.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_nr1w_wr_arb_pkg.sv
// Shared types for the N-read/1-write RAM write-port controller.
package ram_nr1w_wr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE_RST,
        ST_INIT,
        ST_RUN
    } state_t;

endpackage

// File: rtl/ram_nr1w_wr_arb_rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or after the pointer,
// then moves the pointer just past the winner.
module rr_arbiter #(
    parameter  int unsigned REQ_NB = 2,
    localparam int unsigned IDX_W  = (REQ_NB > 1) ? $clog2(REQ_NB) : 1
) (
    input  logic              clk,
    input  logic              s_rst,
    input  logic              en,
    input  logic [REQ_NB-1:0] vld,
    output logic [REQ_NB-1:0] gnt,
    output logic [IDX_W-1:0]  idx
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    // Candidate index is ptr+k folded back into 0..REQ_NB-1 (REQ_NB need not be a power of 2).
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_sum   = '0;
        for (int unsigned k = 0; k < REQ_NB; k++) begin
            w_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(REQ_NB))
                w_sum = w_sum - (IDX_W+1)'(REQ_NB);
            if (!w_found && vld[w_sum[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (en && w_found)
            gnt[w_idx] = 1'b1;
    end

    assign idx = w_idx;

    always_ff @(posedge clk) begin
        if (s_rst)
            r_ptr <= '0;
        else if (en && w_found)
            r_ptr <= (w_idx == IDX_W'(REQ_NB - 1)) ? '0 : w_idx + IDX_W'(1);
    end

endmodule

// File: rtl/ram_nr1w_wr_arb.sv
// Write-port controller: round-robin sharing of the RAM write port plus an
// init sweep that writes INIT_VAL to every address.
module ram_nr1w_wr_arb
    import ram_nr1w_wr_arb_pkg::*;
#(
    parameter  int unsigned      WIDTH       = 32,
    parameter  int unsigned      DEPTH       = 512,
    parameter  int unsigned      REQ_NB      = 2,
    parameter  logic             INIT_AT_RST = 1'b1,
    parameter  logic [WIDTH-1:0] INIT_VAL    = '0,
    localparam int unsigned      ADD_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned      IDX_W       = (REQ_NB > 1) ? $clog2(REQ_NB) : 1
) (
    input  logic                          clk,
    input  logic                          s_rst,
    input  logic                          init_req,
    output logic                          init_busy,
    output logic                          init_done,
    input  logic [REQ_NB-1:0]             req_vld,
    output logic [REQ_NB-1:0]             req_rdy,
    input  logic [REQ_NB-1:0][ADD_W-1:0]  req_add,
    input  logic [REQ_NB-1:0][WIDTH-1:0]  req_data,
    output logic                          wr_en,
    output logic [ADD_W-1:0]              wr_add,
    output logic [WIDTH-1:0]              wr_data
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADD_W-1:0]  r_cnt;
    logic              w_last;
    logic              w_arb_en;
    logic              w_any;
    logic [REQ_NB-1:0] w_gnt;
    logic [IDX_W-1:0]  w_idx;
    logic              r_wr_en;
    logic [ADD_W-1:0]  r_wr_add;
    logic [WIDTH-1:0]  r_wr_data;
    logic              r_init_done;

    assign w_last   = (r_cnt == ADD_W'(DEPTH - 1));
    // init_req pre-empts arbitration in the cycle it arrives.
    assign w_arb_en = (r_state == ST_RUN) && !init_req;
    assign w_any    = |w_gnt;

    rr_arbiter #(.REQ_NB(REQ_NB)) u_arb (
        .clk   (clk),
        .s_rst (s_rst),
        .en    (w_arb_en),
        .vld   (req_vld),
        .gnt   (w_gnt),
        .idx   (w_idx)
    );

    always_ff @(posedge clk) begin
        if (s_rst)
            r_state <= ST_IDLE_RST;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE_RST: w_state_nxt = INIT_AT_RST ? ST_INIT : ST_RUN;
            ST_INIT:     if (w_last) w_state_nxt = ST_RUN;
            ST_RUN:      if (init_req) w_state_nxt = ST_INIT;
            default:     w_state_nxt = ST_IDLE_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            r_cnt       <= '0;
            r_wr_en     <= 1'b0;
            r_wr_add    <= '0;
            r_wr_data   <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_init_done <= (r_state == ST_INIT) && w_last;
            if (r_state == ST_INIT) begin
                r_cnt     <= w_last ? '0 : r_cnt + ADD_W'(1);
                r_wr_en   <= 1'b1;
                r_wr_add  <= r_cnt;
                r_wr_data <= INIT_VAL;
            end else if (w_any) begin
                r_wr_en   <= 1'b1;
                r_wr_add  <= req_add[w_idx];
                r_wr_data <= req_data[w_idx];
            end else begin
                r_wr_en   <= 1'b0;
            end
        end
    end

    assign req_rdy   = w_gnt;
    assign init_busy = (r_state == ST_INIT);
    assign init_done = r_init_done;
    assign wr_en     = r_wr_en;
    assign wr_add    = r_wr_add;
    assign wr_data   = r_wr_data;

endmodule

// File: tb/tb_ram_nr1w_wr_arb.sv
// Bench for ram_nr1w_wr_arb: DEPTH=8, REQ_NB=3, WIDTH=8, INIT_VAL=A5, against a
// transaction-level model of sweep progress, round-robin pointer and write port.
module tb_ram_nr1w_wr_arb;

    localparam int W = 8;
    localparam int D = 8;
    localparam int N = 3;
    localparam int AW = 3;
    localparam logic [W-1:0] IV = 8'hA5;

    logic                clk = 1'b0;
    logic                s_rst;
    logic                init_req;
    logic                init_busy;
    logic                init_done;
    logic [N-1:0]        req_vld;
    logic [N-1:0]        req_rdy;
    logic [N-1:0][AW-1:0] req_add;
    logic [N-1:0][W-1:0]  req_data;
    logic                wr_en;
    logic [AW-1:0]       wr_add;
    logic [W-1:0]        wr_data;

    always #5 clk = ~clk;

    ram_nr1w_wr_arb #(
        .WIDTH       (W),
        .DEPTH       (D),
        .REQ_NB      (N),
        .INIT_AT_RST (1'b1),
        .INIT_VAL    (IV)
    ) dut (
        .clk       (clk),
        .s_rst     (s_rst),
        .init_req  (init_req),
        .init_busy (init_busy),
        .init_done (init_done),
        .req_vld   (req_vld),
        .req_rdy   (req_rdy),
        .req_add   (req_add),
        .req_data  (req_data),
        .wr_en     (wr_en),
        .wr_add    (wr_add),
        .wr_data   (wr_data)
    );

    int tests = 0;
    int fails = 0;

    // Model: m_idle = reset-recovery cycle pending, m_sweep = next sweep address (-1 none).
    bit          m_idle  = 1'b1;
    int          m_sweep = -1;
    int          m_ptr   = 0;
    logic        e_en    = 1'b0;
    logic        e_done  = 1'b0;
    logic [AW-1:0] e_add = '0;
    logic [W-1:0]  e_data = '0;

    logic [16:0] obs;
    assign obs = {req_rdy, init_busy, init_done, wr_en, wr_add, wr_data};

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_rdy();
        int g;
        if (m_idle || m_sweep >= 0 || init_req) return '0;
        g = pick(req_vld, m_ptr);
        if (g < 0) return '0;
        return N'(1 << g);
    endfunction

    function automatic logic [16:0] exp_vec();
        return {exp_rdy(), (m_sweep >= 0), e_done, e_en, e_add, e_data};
    endfunction

    task automatic drive(input logic [N-1:0] v, input logic ini, input logic rst);
        req_vld  = v;
        init_req = ini;
        s_rst    = rst;
        for (int i = 0; i < N; i++) begin
            req_add[i]  = AW'($urandom);
            req_data[i] = W'($urandom);
        end
    endtask

    task automatic advance();
        int g;
        @(posedge clk);
        if (s_rst) begin
            m_idle = 1'b1; m_sweep = -1; m_ptr = 0;
            e_en = 1'b0; e_done = 1'b0; e_add = '0; e_data = '0;
        end else if (m_idle) begin
            m_idle = 1'b0; e_en = 1'b0; e_done = 1'b0; m_sweep = 0;
        end else if (m_sweep >= 0) begin
            e_en = 1'b1; e_add = AW'(m_sweep); e_data = IV;
            e_done = (m_sweep == D - 1);
            m_sweep = (m_sweep == D - 1) ? -1 : m_sweep + 1;
        end else begin
            e_done = 1'b0;
            g = init_req ? -1 : pick(req_vld, m_ptr);
            if (init_req) m_sweep = 0;
            if (g >= 0) begin
                e_en = 1'b1; e_add = req_add[g]; e_data = req_data[g];
                m_ptr = (g + 1) % N;
            end else begin
                e_en = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            drive(N'($urandom), 1'b0, 1'b1);
            @(negedge clk);
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL reset c=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_init_sweep();
        int n_en = 0;
        int n_done = 0;
        for (int c = 0; c < 11; c++) begin
            drive((m_idle || m_sweep >= 0) ? N'($urandom) : '0, 1'b0, 1'b0);
            @(negedge clk);
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL init_sweep c=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            if (wr_en) n_en++;
            if (init_done) begin
                n_done++;
                tests++;
                if (wr_add !== AW'(D - 1)) begin
                    fails++;
                    $display("FAIL init_sweep_done_addr got=%0d exp=%0d", wr_add, D - 1);
                end
            end
            advance();
        end
        tests++;
        if (n_en != D || n_done != 1) begin
            fails++;
            $display("FAIL init_sweep_counts got en=%0d done=%0d exp en=%0d done=1", n_en, n_done, D);
        end
    endtask

    task automatic test_rr_all_valid();
        for (int c = 0; c < 7; c++) begin
            drive((c < 6) ? 3'b111 : 3'b000, 1'b0, 1'b0);
            @(negedge clk);
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL rr_all c=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            if (c < 6) begin
                tests++;
                if (req_rdy !== N'(1 << (c % N))) begin
                    fails++;
                    $display("FAIL rr_all_order c=%0d got=%b exp=%b", c, req_rdy, N'(1 << (c % N)));
                end
            end
            advance();
        end
    endtask

    task automatic test_rr_pattern();
        logic [N-1:0] pv [4];
        logic [N-1:0] pr [4];
        pv = '{3'b100, 3'b101, 3'b101, 3'b000};
        pr = '{3'b100, 3'b001, 3'b100, 3'b000};
        for (int c = 0; c < 4; c++) begin
            drive(pv[c], 1'b0, 1'b0);
            @(negedge clk);
            tests++;
            if (obs !== exp_vec() || req_rdy !== pr[c]) begin
                fails++;
                $display("FAIL rr_pattern c=%0d got=%h rdy=%b exp=%h rdy=%b", c, obs, req_rdy, exp_vec(), pr[c]);
            end
            advance();
        end
    endtask

    task automatic test_init_during_run();
        int sp;
        int n_en = 0;
        int n_done = 0;
        sp = m_ptr;
        drive(3'b111, 1'b1, 1'b0);
        @(negedge clk);
        tests++;
        if (req_rdy !== '0 || obs !== exp_vec()) begin
            fails++;
            $display("FAIL init_run_pre got=%h exp=%h", obs, exp_vec());
        end
        advance();
        for (int c = 0; c < 15; c++) begin
            drive(3'b111, 1'b0, 1'b0);
            @(negedge clk);
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL init_run c=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            if (wr_en) n_en++;
            if (init_done) begin
                n_done++;
                tests++;
                if (req_rdy !== N'(1 << sp)) begin
                    fails++;
                    $display("FAIL init_run_resume got=%b exp=%b", req_rdy, N'(1 << sp));
                end
            end
            advance();
            if (n_done != 0) break;
        end
        tests++;
        if (n_en != D || n_done != 1) begin
            fails++;
            $display("FAIL init_run_counts got en=%0d done=%0d exp en=%0d done=1", n_en, n_done, D);
        end
    endtask

    task automatic test_init_req_ignored();
        int n_en = 0;
        int n_done = 0;
        drive('0, 1'b1, 1'b0);
        @(negedge clk);
        advance();
        for (int c = 0; c < 15; c++) begin
            drive((m_sweep >= 0) ? N'($urandom) : '0, (m_sweep == 3), 1'b0);
            @(negedge clk);
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL init_ignored c=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            if (wr_en) n_en++;
            if (init_done) n_done++;
            advance();
        end
        tests++;
        if (n_en != D || n_done != 1) begin
            fails++;
            $display("FAIL init_ignored_counts got en=%0d done=%0d exp en=%0d done=1", n_en, n_done, D);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n_en = 0;
        int first = -1;
        drive('0, 1'b1, 1'b0);
        @(negedge clk);
        advance();
        for (int c = 0; c < 10 && m_sweep != 5; c++) begin
            drive('0, 1'b0, 1'b0);
            @(negedge clk);
            advance();
        end
        drive('0, 1'b0, 1'b1);
        @(negedge clk);
        tests++;
        if (obs !== exp_vec()) begin
            fails++;
            $display("FAIL rst_mid_assert got=%h exp=%h", obs, exp_vec());
        end
        advance();
        drive('0, 1'b0, 1'b0);
        @(negedge clk);
        tests++;
        if (wr_en !== 1'b0 || obs !== exp_vec()) begin
            fails++;
            $display("FAIL rst_mid_after got=%h exp=%h", obs, exp_vec());
        end
        advance();
        for (int c = 0; c < 12; c++) begin
            drive('0, 1'b0, 1'b0);
            @(negedge clk);
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL rst_mid_sweep c=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            if (wr_en) begin
                if (first < 0) first = int'(wr_add);
                n_en++;
            end
            advance();
        end
        tests++;
        if (n_en != D || first != 0) begin
            fails++;
            $display("FAIL rst_mid_restart got en=%0d first=%0d exp en=%0d first=0", n_en, first, D);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            drive(N'($urandom), ($urandom_range(99) < 3), ($urandom_range(99) < 1));
            @(negedge clk);
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL random c=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            advance();
        end
    endtask

    initial begin
        drive('0, 1'b0, 1'b1);
        advance();
        test_reset();
        test_init_sweep();
        test_rr_all_valid();
        test_rr_pattern();
        test_init_during_run();
        test_init_req_ignored();
        test_reset_mid_sweep();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
